// File: rtl/dram_chip_model.sv
// Clocked responder for an asynchronous page-mode DRAM chip: stores data, answers
// /RAS-/CAS read and early-write cycles, counts CBR refreshes and flags protocol faults.
module dram_chip_model #(
    parameter int ROW_WIDTH       = 8,
    parameter int COL_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_REFRESH_GAP = 300,
    parameter int MAX_RAS_CYCLES  = 16,
    localparam int _ADDR_WIDTH    = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   nRAS,
    input  logic                   nCAS,
    input  logic                   nOE,
    input  logic                   nWE,
    input  logic [_ADDR_WIDTH-1:0] dramAddr,
    inout  wire  [DATA_WIDTH-1:0]  dramData,
    input  logic                   clearErrors,
    output logic [ROW_WIDTH-1:0]   refreshCount,
    output logic [2:0]             errorFlags
);

    localparam int MEM_AW    = ROW_WIDTH + COL_WIDTH;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int GAP_W     = $clog2(MAX_REFRESH_GAP + 2);
    localparam int RAS_W     = $clog2(MAX_RAS_CYCLES + 2);
    localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(MAX_REFRESH_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_REFRESH_GAP);
    localparam logic [RAS_W-1:0] RAS_SAT   = RAS_W'(MAX_RAS_CYCLES + 1);
    localparam logic [RAS_W-1:0] RAS_LIMIT = RAS_W'(MAX_RAS_CYCLES);

    typedef enum logic [1:0] {
        ST_CLOSED   = 2'd0,
        ST_ROW_OPEN = 2'd1,
        ST_REFRESH  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   prev_ras_q, prev_cas_q;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [ROW_WIDTH-1:0]   refresh_cnt_q, refresh_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [RAS_W-1:0]       ras_cnt_q, ras_cnt_d;
    logic [2:0]             err_q, err_d;
    logic [2:0]             err_set_s;

    logic                   ras_fall_s, cas_fall_s;
    logic                   cbr_s, row_open_evt_s, conflict_s;
    logic                   wr_en_s, rd_drive_s;
    logic [ROW_WIDTH-1:0]   wr_row_s;
    logic [COL_WIDTH-1:0]   col_s;
    logic [MEM_AW-1:0]      wr_addr_s, rd_addr_s;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

    // Strobe edge detection and cycle classification
    always_comb begin
        ras_fall_s     = ~nRAS & prev_ras_q;
        cas_fall_s     = ~nCAS & prev_cas_q;
        col_s          = dramAddr[COL_WIDTH-1:0];
        conflict_s     = ~nCAS & ~nOE & ~nWE;
        cbr_s          = (state_q == ST_CLOSED) & ras_fall_s & ~prev_cas_q;
        row_open_evt_s = (state_q == ST_CLOSED) & ras_fall_s & prev_cas_q;
    end

    // State register and strobe history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLOSED;
            prev_ras_q <= 1'b1;
            prev_cas_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            prev_ras_q <= nRAS;
            prev_cas_q <= nCAS;
        end
    end

    // Next-state logic; any sampled-high /RAS ends the row or refresh cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLOSED: begin
                if (row_open_evt_s) begin
                    state_d = ST_ROW_OPEN;
                end else if (cbr_s) begin
                    state_d = ST_REFRESH;
                end else begin
                    state_d = ST_CLOSED;
                end
            end
            ST_ROW_OPEN, ST_REFRESH: begin
                if (nRAS) begin
                    state_d = ST_CLOSED;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_CLOSED;
        endcase
    end

    // Array strobes; a /CAS fall on the same edge as the row open uses the live row address
    always_comb begin
        if (state_q == ST_ROW_OPEN) begin
            wr_row_s = row_q;
        end else begin
            wr_row_s = dramAddr[ROW_WIDTH-1:0];
        end
        wr_en_s    = cas_fall_s & ~nWE & ~conflict_s & ~reset
                   & ((state_q == ST_ROW_OPEN) | row_open_evt_s);
        rd_drive_s = (state_q == ST_ROW_OPEN) & ~nCAS & ~nOE & nWE;
        wr_addr_s  = {wr_row_s, col_s};
        rd_addr_s  = {row_q, col_s};
    end

    // Row latch, refresh counter, watchdogs and sticky error flags
    always_comb begin
        if (row_open_evt_s) begin
            row_d = dramAddr[ROW_WIDTH-1:0];
        end else begin
            row_d = row_q;
        end

        if (cbr_s) begin
            refresh_cnt_d = refresh_cnt_q + {{(ROW_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            refresh_cnt_d = refresh_cnt_q;
        end

        if (cbr_s) begin
            gap_cnt_d = {GAP_W{1'b0}};
        end else if (gap_cnt_q == GAP_SAT) begin
            gap_cnt_d = gap_cnt_q;
        end else begin
            gap_cnt_d = gap_cnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
        end

        if (nRAS) begin
            ras_cnt_d = {RAS_W{1'b0}};
        end else if (ras_cnt_q == RAS_SAT) begin
            ras_cnt_d = ras_cnt_q;
        end else begin
            ras_cnt_d = ras_cnt_q + {{(RAS_W-1){1'b0}}, 1'b1};
        end

        // New violations win over a simultaneous clear
        err_set_s = {(ras_cnt_d > RAS_LIMIT), conflict_s, (gap_cnt_d > GAP_LIMIT)};
        if (clearErrors) begin
            err_d = err_set_s;
        end else begin
            err_d = err_q | err_set_s;
        end
    end

    // Bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q         <= {ROW_WIDTH{1'b0}};
            refresh_cnt_q <= {ROW_WIDTH{1'b0}};
            gap_cnt_q     <= {GAP_W{1'b0}};
            ras_cnt_q     <= {RAS_W{1'b0}};
            err_q         <= 3'b000;
        end else begin
            row_q         <= row_d;
            refresh_cnt_q <= refresh_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ras_cnt_q     <= ras_cnt_d;
            err_q         <= err_d;
        end
    end

    // Storage array; contents survive reset like a real DRAM
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= dramData;
        end
    end

    assign dramData     = rd_drive_s ? mem_q[rd_addr_s] : {DATA_WIDTH{1'bz}};
    assign refreshCount = refresh_cnt_q;
    assign errorFlags   = err_q;

endmodule

// File: tb/tb_dram_chip_model.sv
// Randomized scoreboard bench for dram_chip_model: a cycle-level reference model predicts
// read data and status; monitors compare whenever the chip drives data or a clock edge retires.
module tb_dram_chip_model;

    logic       clk = 1'b0;
    logic       reset;
    logic       nRAS, nCAS, nOE, nWE, clearErrors;
    logic [7:0] dramAddr;
    wire  [7:0] dramData;
    logic       drv_en;
    logic [7:0] drv_val;
    logic [7:0] refreshCount;
    logic [2:0] errorFlags;

    always #5 clk = ~clk;

    assign dramData = drv_en ? drv_val : 8'hzz;

    dram_chip_model dut (
        .clk(clk), .reset(reset), .nRAS(nRAS), .nCAS(nCAS), .nOE(nOE), .nWE(nWE),
        .dramAddr(dramAddr), .dramData(dramData), .clearErrors(clearErrors),
        .refreshCount(refreshCount), .errorFlags(errorFlags)
    );

    typedef struct { bit care; logic [7:0] data; } rd_exp_t;
    typedef struct { logic [2:0] flags; logic [7:0] rcnt; } st_exp_t;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    bit      mon_en   = 1'b0;

    // Reference model: 0 = closed, 1 = row open, 2 = refresh
    int         m_mode, m_row, m_refcnt, m_gap, m_run;
    bit         m_pr, m_pc;
    logic [2:0] m_flags;
    logic [7:0] m_mem [int];

    function void model_reset();
        m_mode = 0; m_row = 0; m_refcnt = 0; m_gap = 0; m_run = 0;
        m_pr = 1'b1; m_pc = 1'b1; m_flags = 3'b000;
    endfunction

    function void model_edge(bit ras, bit cas, bit oe, bit we, int addr, logic [7:0] din, bit clr);
        bit rf, cf, conf, cbr;
        logic [2:0] set;
        rf   = !ras && m_pr;
        cf   = !cas && m_pc;
        conf = !cas && !oe && !we;
        cbr  = (m_mode == 0) && rf && !m_pc;
        if (m_mode == 1 && cf && !we && !conf) m_mem[m_row * 256 + addr] = din;
        if (m_mode == 0 && rf) begin
            if (m_pc) begin m_mode = 1; m_row = addr; end
            else m_mode = 2;
        end else if (ras) m_mode = 0;
        if (cbr) begin m_refcnt = (m_refcnt + 1) % 256; m_gap = 0; end
        else if (m_gap < 301) m_gap++;
        if (ras) m_run = 0;
        else if (m_run < 17) m_run++;
        set = 3'b000;
        set[0] = (m_gap > 300);
        set[1] = conf;
        set[2] = (m_run > 16);
        m_flags = (clr ? 3'b000 : m_flags) | set;
        m_pr = ras;
        m_pc = cas;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle: pins change at negedge, model predicts the read window and the next edge
    task automatic cyc(input bit ras, input bit cas, input bit oe, input bit we,
                       input logic [7:0] addr, input bit den, input logic [7:0] din, input bit clr);
        rd_exp_t r;
        st_exp_t s;
        int idx;
        @(negedge clk);
        nRAS = ras; nCAS = cas; nOE = oe; nWE = we; dramAddr = addr;
        drv_en = den; drv_val = din; clearErrors = clr;
        if (m_mode == 1 && !cas && !oe && we) begin
            idx    = m_row * 256 + int'(addr);
            r.care = m_mem.exists(idx);
            r.data = r.care ? m_mem[idx] : 8'h00;
            rd_q.push_back(r);
        end
        model_edge(ras, cas, oe, we, int'(addr), din, clr);
        s.flags = m_flags;
        s.rcnt  = 8'(m_refcnt);
        st_q.push_back(s);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic op_idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, 1, 8'h00, 0, 8'h00, (i == 0) ? clr : 1'b0);
    endtask

    task automatic op_write(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        cyc(0, 1, 1, 1, r, 0, 8'h00, 0);
        cyc(0, 0, 1, 0, c, 1, d, 0);
        cyc(0, 1, 1, 1, c, 0, 8'h00, 0);
        cyc(1, 1, 1, 1, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic op_read(input logic [7:0] r, input logic [7:0] c, input bit page, input logic [7:0] c2);
        cyc(0, 1, 1, 1, r, 0, 8'h00, 0);
        cyc(0, 0, 0, 1, c, 0, 8'h00, 0);
        if (page) cyc(0, 0, 0, 1, c2, 0, 8'h00, 0);
        cyc(0, 1, 1, 1, c, 0, 8'h00, 0);
        cyc(1, 1, 1, 1, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic op_refresh();
        cyc(1, 0, 1, 1, 8'h00, 0, 8'h00, 0);
        cyc(0, 0, 1, 1, 8'h00, 0, 8'h00, 0);
        cyc(1, 1, 1, 1, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic op_conflict(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        cyc(0, 1, 1, 1, r, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, c, 1, d, 0);
        cyc(0, 1, 1, 1, c, 0, 8'h00, 0);
        cyc(1, 1, 1, 1, 8'h00, 0, 8'h00, 0);
    endtask

    // Read-data monitor: the chip must drive exactly when a read is expected
    always @(negedge clk) begin
        rd_exp_t e;
        #2;
        if (mon_en) begin
            n_checks++;
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                if (dut.rd_drive_s !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rd_drive: chip not driving, expected data 0x%0h", e.data);
                end else if (e.care && dramData !== e.data) begin
                    n_errors++;
                    $display("FAIL rd_data: got 0x%0h, expected 0x%0h", dramData, e.data);
                end
            end else if (dut.rd_drive_s !== 1'b0) begin
                n_errors++;
                $display("FAIL hiz: chip drives 0x%0h outside a read window", dramData);
            end
        end
    end

    // Status monitor: refresh counter and error flags after every edge
    always @(posedge clk) begin
        st_exp_t s;
        #1;
        if (mon_en && st_q.size() > 0) begin
            s = st_q.pop_front();
            n_checks++;
            if (errorFlags !== s.flags || refreshCount !== s.rcnt) begin
                n_errors++;
                $display("FAIL status: flags=%b rcnt=0x%0h, expected flags=%b rcnt=0x%0h",
                         errorFlags, refreshCount, s.flags, s.rcnt);
            end
        end
    end

    initial begin
        reset = 1'b1; nRAS = 1'b1; nCAS = 1'b1; nOE = 1'b1; nWE = 1'b1;
        dramAddr = 8'h00; drv_en = 1'b0; drv_val = 8'h00; clearErrors = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rcnt", int'(refreshCount), 0);
        chk("reset_flags", int'(errorFlags), 0);
        chk("reset_hiz", int'(dut.rd_drive_s), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        op_write(8'h12, 8'h34, 8'hA5);
        op_read(8'h12, 8'h34, 0, 8'h00);

        repeat (3) op_refresh();
        settle();
        chk("cbr_3", int'(refreshCount), 3);
        chk("cbr_flags", int'(errorFlags), 0);
        repeat (256) op_refresh();
        settle();
        chk("cbr_wrap", int'(refreshCount), 3);
        chk("cbr_wrap_flags", int'(errorFlags), 0);
        op_read(8'h12, 8'h34, 1, 8'h35);

        op_refresh();
        op_idle(299, 0);
        settle();
        chk("gap_300", int'(errorFlags), 0);
        op_idle(1, 0);
        settle();
        chk("gap_301", int'(errorFlags), 1);
        op_idle(5, 0);
        settle();
        chk("gap_sticky", int'(errorFlags), 1);
        op_refresh();
        op_idle(1, 1);
        settle();
        chk("gap_clear", int'(errorFlags), 0);

        op_write(8'h21, 8'h07, 8'h5A);
        op_conflict(8'h21, 8'h07, 8'hC3);
        settle();
        chk("conflict_flag", int'(errorFlags), 2);
        op_read(8'h21, 8'h07, 0, 8'h00);
        op_idle(1, 1);
        settle();
        chk("conflict_clear", int'(errorFlags), 0);

        repeat (16) cyc(0, 1, 1, 1, 8'h40, 0, 8'h00, 0);
        settle();
        chk("ras_16", int'(errorFlags), 0);
        cyc(0, 1, 1, 1, 8'h40, 0, 8'h00, 0);
        settle();
        chk("ras_17", int'(errorFlags), 4);
        cyc(1, 1, 1, 1, 8'h00, 0, 8'h00, 1);
        settle();
        chk("ras_clear", int'(errorFlags), 0);

        for (int k = 0; k < 250; k++) begin
            logic [7:0] r, c, c2, d;
            r  = 8'($urandom_range(0, 3));
            c  = 8'($urandom_range(0, 7));
            c2 = 8'($urandom_range(0, 7));
            d  = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 6))
                0, 1:    op_write(r, c, d);
                2, 3:    op_read(r, c, 1'($urandom_range(0, 1)), c2);
                4:       op_refresh();
                5:       op_idle($urandom_range(1, 8), 1'($urandom_range(0, 1)));
                default: op_conflict(r, c, d);
            endcase
        end

        // Reset in the middle of an active read window
        cyc(0, 1, 1, 1, 8'h12, 0, 8'h00, 0);
        cyc(0, 0, 0, 1, 8'h34, 0, 8'h00, 0);
        #4;
        reset  = 1'b1;
        mon_en = 1'b0;
        rd_q.delete();
        st_q.delete();
        #1;
        chk("rst_mid_hiz", int'(dut.rd_drive_s), 0);
        chk("rst_mid_rcnt", int'(refreshCount), 0);
        chk("rst_mid_flags", int'(errorFlags), 0);
        @(negedge clk);
        nRAS = 1'b1; nCAS = 1'b1; nOE = 1'b1; nWE = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        op_read(8'h12, 8'h34, 0, 8'h00);
        op_refresh();
        settle();
        chk("post_rst_rcnt", int'(refreshCount), 1);

        @(posedge clk);
        #3;
        chk("rd_drain", rd_q.size(), 0);
        chk("st_drain", st_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
